rx_frame_ctrl: RTL and testbench
================================

# rx_frame_ctrl

Receive-frame sequencer for the 802.15.4 O-QPSK receiver, placed directly after the bit-recovery/CDR chain. It gates phase samples into the CDR and hunts the recovered bit stream for preamble and SFD. It then parses the PHR length, assembles payload bytes LSB-first, and flushes the CDR between frames. It also aborts stalled frames through a bit watchdog.

## Interface
- PRE_MIN, 24: consecutive zero bits required before an SFD is accepted.
- MIN_LEN, 5: smallest legal PSDU length, in bytes.
- TIMEOUT_CYC, 512: clocks without `data_en_i` before an in-frame abort.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_en_i  in  1  receiver enable.
- ph_valid_i  in  1  phase-sample valid from the demodulator.
- cdr_ph_valid_o  out  1  gated phase valid to the CDR: `ph_valid_i & (state != IDLE)`, combinational.
- cdr_flush_o  out  1  one-cycle CDR clear pulse.
- data_en_i  in  1  recovered-bit strobe from the CDR.
- data_i  in  1  recovered bit.
- byte_o  out  8  assembled PSDU byte.
- byte_valid_o  out  1  one-cycle strobe qualifying `byte_o`.
- sfd_det_o  out  1  one-cycle pulse on SFD match.
- frame_len_o  out  7  PHR length; holds until the next SFD.
- frame_done_o  out  1  one-cycle pulse on a complete frame.
- frame_err_o  out  1  one-cycle pulse on length error or timeout.
- fcs_ok_o  out  1  FCS check result, valid while `frame_done_o` is high.
- busy_o  out  1  high in the SFD, PHR and PAYLOAD states.

## Operation
- **Reset values:** all registered outputs are 0 and the state is IDLE.
- **Bit handling:** a bit is consumed only on a `data_en_i` cycle. All other cycles only advance the watchdog.
- **IDLE:** entered on `rx_en_i=1` -> HUNT, with `cdr_flush_o` pulsed.
- **HUNT:** `zero_cnt` (6 bits, saturating) increments on each 0 bit.
  - A 1 bit with `zero_cnt >= PRE_MIN` -> SFD. The shift register is loaded with that bit and `bit_cnt` is set to 1.
  - A 1 bit below the threshold clears `zero_cnt`.
- **SFD:** collects bits to 8, LSB-first.
  - Byte == 8'hA7 -> PHR, with `sfd_det_o` pulsed.
  - Any other byte -> HUNT with `zero_cnt=0`.
- **PHR:** collects 8 bits and latches `len = bits[6:0]`; bit 7 is ignored.
  - `len < MIN_LEN` -> ERR.
  - Otherwise -> PAYLOAD, with `frame_len_o` updated.
- **PAYLOAD:** every 8th bit emits `byte_o`/`byte_valid_o` and decrements the remaining count.
  - The last byte -> DONE.
- **DONE:** lasts one cycle. Pulses `frame_done_o` and `cdr_flush_o`, then -> HUNT.
- **ERR:** lasts one cycle. Pulses `frame_err_o` and `cdr_flush_o`, then -> HUNT.
- **Watchdog:** a counter cleared on every `data_en_i` and while in IDLE or HUNT. Reaching `TIMEOUT_CYC` in SFD, PHR or PAYLOAD -> ERR.
- **Disable:** `rx_en_i=0` in any state -> IDLE on the next edge. Pulses `cdr_flush_o` and no `frame_err_o`. This takes priority over every other transition.
- **Timeout vs. last bit:** a watchdog expiry on the same cycle as a final-bit `data_en_i` is resolved in favour of the bit.

## Timing
- `byte_valid_o` and `byte_o` are registered and rise one clock after the `data_en_i` carrying bit 7 of the byte.
- `sfd_det_o` rises one clock after the last SFD bit.
- `frame_done_o` rises one clock after the final `byte_valid_o`.
- The DONE and ERR states never consume a bit. A `data_en_i` arriving in those cycles is dropped.
- Back-to-back frames need no gap beyond that single DONE cycle.

## Configuration
- **`RX_FRAME_CTRL_FCS_EN` defined:**
  - A bit-serial CRC-16 (polynomial 0x1021, reflected form 0x8408, init 0) runs over every PSDU bit, FCS included.
  - The CRC is cleared on SFD.
  - `fcs_ok_o = (crc == 0)`, registered on entry to DONE.
- **Macro undefined:** no CRC logic is built and `fcs_ok_o` is tied to 0.

## Structure
- Package `rx_frame_pkg` holds:
  - the state enum (IDLE, HUNT, SFD, PHR, PAYLOAD, DONE, ERR);
  - `SFD_BYTE` = 8'hA7;
  - `CRC_POLY_REF` = 16'h8408;
  - `LEN_W` = 7.
- Sub-module `rx_fcs_crc16`: serial CRC with clear/enable/bit inputs and a 16-bit state output. It is instantiated only under the macro.

## Test plan
- **Nominal frame:** 32 zeros, SFD A7, PHR 05, payload 01 02 03 04 05 -> `sfd_det_o` ×1, five `byte_valid_o` strobes carrying 01..05, `frame_len_o=5`, then `frame_done_o`.
- **Short preamble:** 10 zeros then A7 -> no `sfd_det_o`, state remains HUNT. A following 24 zeros + A7 is then accepted.
- **Illegal length:** PHR 03 -> `frame_err_o` one clock after the PHR's last bit, `cdr_flush_o` pulsed, no bytes emitted.
- **Stall:** `data_en_i` stops after 2 payload bytes -> `frame_err_o` exactly `TIMEOUT_CYC` clocks after the last strobe.
- **Disable mid-frame:** `rx_en_i` dropped during the 3rd payload byte -> IDLE next clock, no error pulse, and `cdr_ph_valid_o` stays 0 while `ph_valid_i` toggles.
- **FCS (macro on):** frame 02 00 56 plus the FCS from the bench model -> `fcs_ok_o=1`. With one FCS bit flipped -> `fcs_ok_o=0`, still with `frame_done_o`.

Source files
------------

// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the 802.15.4 receive-frame sequencer.
package rx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    SFD,
    PHR,
    PAYLOAD,
    DONE,
    ERR
  } rx_state_e;

  localparam logic [7:0]  SFD_BYTE     = 8'hA7;
  localparam logic [15:0] CRC_POLY_REF = 16'h8408;
  localparam int          LEN_W        = 7;

  // One LSB-first step of the reflected CRC-16/CCITT.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return {1'b0, crc[15:1]} ^ ((crc[0] ^ b) ? CRC_POLY_REF : 16'h0000);
  endfunction

endpackage

// File: rtl/rx_fcs_crc16.sv
// Bit-serial reflected CRC-16 over PSDU bits; only built when RX_FRAME_CTRL_FCS_EN is defined.
module rx_fcs_crc16
  import rx_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc_reg <= '0;
    end else if (en) begin
      crc_reg <= crc16_step(crc_reg, din);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive-frame sequencer: preamble/SFD hunt, PHR length, LSB-first payload bytes, bit watchdog.
// Optional FCS check enabled by defining RX_FRAME_CTRL_FCS_EN.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int PRE_MIN     = 24,
  parameter int MIN_LEN     = 5,
  parameter int TIMEOUT_CYC = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_en_i,
  input  logic             ph_valid_i,
  output logic             cdr_ph_valid_o,
  output logic             cdr_flush_o,
  input  logic             data_en_i,
  input  logic             data_i,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o,
  output logic             sfd_det_o,
  output logic [LEN_W-1:0] frame_len_o,
  output logic             frame_done_o,
  output logic             frame_err_o,
  output logic             fcs_ok_o,
  output logic             busy_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  rx_state_e        state_reg, state_next;
  logic [5:0]       zero_cnt_reg;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt_reg;
  logic [LEN_W-1:0] bytes_left_reg;
  logic [WD_W-1:0]  wd_cnt_reg;
  logic [7:0]       byte_reg;
  logic [LEN_W-1:0] frame_len_reg;
  logic             byte_valid_reg, sfd_det_reg, frame_done_reg, frame_err_reg, flush_reg;

  logic       bit_take, byte_full, wd_expire;
  logic [7:0] byte_next;
  logic       sfd_next, byte_valid_next, done_next, err_next, flush_next, len_load;

  assign bit_take  = data_en_i && (state_reg inside {HUNT, SFD, PHR, PAYLOAD});
  assign byte_next = {data_i, shift_reg[7:1]};
  assign byte_full = bit_take && (state_reg != HUNT) && (bit_cnt_reg == 3'd7);
  // Any bit strobe beats an expiring watchdog on the same cycle.
  assign wd_expire = (state_reg inside {SFD, PHR, PAYLOAD}) && !data_en_i &&
                     (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!rx_en_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: state_next = HUNT;
        HUNT: if (bit_take && data_i && (zero_cnt_reg >= 6'(PRE_MIN))) state_next = SFD;
        SFD: begin
          if (byte_full)      state_next = (byte_next == SFD_BYTE) ? PHR : HUNT;
          else if (wd_expire) state_next = ERR;
        end
        PHR: begin
          if (byte_full)      state_next = (byte_next[LEN_W-1:0] < LEN_W'(MIN_LEN)) ? ERR : PAYLOAD;
          else if (wd_expire) state_next = ERR;
        end
        PAYLOAD: begin
          if (byte_full && (bytes_left_reg == LEN_W'(1))) state_next = DONE;
          else if (wd_expire)                             state_next = ERR;
        end
        DONE, ERR: state_next = HUNT;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o          = state_reg inside {SFD, PHR, PAYLOAD};
    cdr_ph_valid_o  = ph_valid_i && (state_reg != IDLE);
    sfd_next        = (state_reg == SFD) && (state_next == PHR);
    byte_valid_next = (state_reg == PAYLOAD) && byte_full && rx_en_i;
    done_next       = (state_reg == DONE) && (state_next == HUNT);
    err_next        = (state_next == ERR);
    flush_next      = (state_next != state_reg) &&
                      ((state_next inside {IDLE, ERR}) || (state_reg inside {IDLE, DONE}));
    len_load        = (state_reg == PHR) && (state_next == PAYLOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_cnt_reg   <= '0;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      bytes_left_reg <= '0;
      wd_cnt_reg     <= '0;
      byte_reg       <= '0;
      frame_len_reg  <= '0;
      byte_valid_reg <= 1'b0;
      sfd_det_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      flush_reg      <= 1'b0;
    end else begin
      byte_valid_reg <= byte_valid_next;
      sfd_det_reg    <= sfd_next;
      frame_done_reg <= done_next;
      frame_err_reg  <= err_next;
      flush_reg      <= flush_next;

      if (state_reg != HUNT)  zero_cnt_reg <= '0;
      else if (bit_take)      zero_cnt_reg <= data_i ? 6'd0 :
                                              (zero_cnt_reg == 6'h3F) ? zero_cnt_reg : zero_cnt_reg + 6'd1;

      if (bit_take) shift_reg <= byte_next;

      // The preamble-ending 1 is SFD bit 0, so the SFD byte starts one bit in.
      if (state_reg == HUNT) bit_cnt_reg <= 3'd1;
      else if (bit_take)     bit_cnt_reg <= bit_cnt_reg + 3'd1;

      if (len_load) begin
        frame_len_reg  <= byte_next[LEN_W-1:0];
        bytes_left_reg <= byte_next[LEN_W-1:0];
      end else if (byte_valid_next) begin
        bytes_left_reg <= bytes_left_reg - LEN_W'(1);
      end

      if (byte_valid_next) byte_reg <= byte_next;

      if ((state_reg inside {IDLE, HUNT}) || data_en_i) wd_cnt_reg <= '0;
      else                                              wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
    end
  end

  assign byte_o       = byte_reg;
  assign byte_valid_o = byte_valid_reg;
  assign sfd_det_o    = sfd_det_reg;
  assign frame_len_o  = frame_len_reg;
  assign frame_done_o = frame_done_reg;
  assign frame_err_o  = frame_err_reg;
  assign cdr_flush_o  = flush_reg;

`ifdef RX_FRAME_CTRL_FCS_EN
  logic [15:0] crc;
  logic        fcs_ok_reg;

  rx_fcs_crc16 u_fcs (
    .clk (clk),
    .rst (rst),
    .clr (sfd_next),
    .en  (bit_take && (state_reg == PAYLOAD)),
    .din (data_i),
    .crc (crc)
  );

  // Sampled in DONE so the residue already includes the final FCS bit.
  always_ff @(posedge clk) begin
    if (rst)                    fcs_ok_reg <= 1'b0;
    else if (state_reg == DONE) fcs_ok_reg <= (crc == 16'h0000);
  end

  assign fcs_ok_o = fcs_ok_reg;
`else
  assign fcs_ok_o = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: directed frames, expected events queued, monitor compares.
module tb_rx_frame_ctrl;

  localparam int TIMEOUT_CYC = 512;
  localparam int K_SFD = 0, K_BYTE = 1, K_DONE = 2, K_ERR = 3;
`ifdef RX_FRAME_CTRL_FCS_EN
  localparam int FCS_ON = 1;
`else
  localparam int FCS_ON = 0;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       rx_en_i = 1'b0, ph_valid_i = 1'b0, data_en_i = 1'b0, data_i = 1'b0;
  logic       cdr_ph_valid_o, cdr_flush_o, byte_valid_o, sfd_det_o;
  logic       frame_done_o, frame_err_o, fcs_ok_o, busy_o;
  logic [7:0] byte_o;
  logic [6:0] frame_len_o;

  rx_frame_ctrl #(.PRE_MIN(24), .MIN_LEN(5), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_en_i        (rx_en_i),
    .ph_valid_i     (ph_valid_i),
    .cdr_ph_valid_o (cdr_ph_valid_o),
    .cdr_flush_o    (cdr_flush_o),
    .data_en_i      (data_en_i),
    .data_i         (data_i),
    .byte_o         (byte_o),
    .byte_valid_o   (byte_valid_o),
    .sfd_det_o      (sfd_det_o),
    .frame_len_o    (frame_len_o),
    .frame_done_o   (frame_done_o),
    .frame_err_o    (frame_err_o),
    .fcs_ok_o       (fcs_ok_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int data;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0, fails = 0, flush_cnt = 0, exp_flush = 0;

  function automatic string kname(input int k);
    case (k)
      K_SFD:   return "sfd";
      K_BYTE:  return "byte";
      K_DONE:  return "done";
      default: return "err";
    endcase
  endfunction

  // Reflected CRC-16, init 0, over an LSB-first bit stream.
  function automatic logic [15:0] crc_stream(input logic [39:0] msg, input int nbits);
    logic [15:0] c;
    c = 16'h0000;
    for (int i = 0; i < nbits; i++) begin
      if (c[0] ^ msg[i]) c = (c >> 1) ^ 16'h8408;
      else               c = c >> 1;
    end
    return c;
  endfunction

  task automatic expect_ev(input int kind, input int data, input int at);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, got, exp, cyc);
    end else begin
      $display("[TB] %s ok: %0h", name, got);
    end
  endtask

  task automatic check_event(input int kind, input int data);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s: got data %0h at cyc %0d, expected no event", kname(kind), data, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.data != data || (e.at >= 0 && e.at != cyc)) begin
      fails++;
      $display("FAIL event_%s: got %s data %0h cyc %0d, expected %s data %0h cyc %0d",
               kname(e.kind), kname(kind), data, cyc, kname(e.kind), e.data, e.at);
    end else begin
      $display("[TB] event %s data %0h cyc %0d ok", kname(kind), data, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sfd_det_o)    check_event(K_SFD, 0);
      if (byte_valid_o) check_event(K_BYTE, int'(byte_o));
      if (frame_done_o) check_event(K_DONE, int'({cdr_flush_o, fcs_ok_o, frame_len_o}));
      if (frame_err_o)  check_event(K_ERR, int'(cdr_flush_o));
      if (cdr_flush_o)  flush_cnt++;
    end
  end

  task automatic send_bit(input logic b);
    data_en_i = 1'b1;
    data_i    = b;
    @(posedge clk);
    #1;
    data_en_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    send_zeros(32);
    send_byte(8'hA7);
    send_byte(len);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
  endtask

  logic [15:0] fcs;
  int          nom_fcs;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst        = 1'b0;
    ph_valid_i = 1'b1;
    @(negedge clk);
    check("reset_outputs", int'({sfd_det_o, byte_valid_o, byte_o, frame_len_o, frame_done_o,
                                 frame_err_o, fcs_ok_o, cdr_flush_o, busy_o}), 0);
    check("idle_ph_gate", int'(cdr_ph_valid_o), 0);

    @(posedge clk);
    #1;
    rx_en_i = 1'b1;
    idle(2);
    exp_flush = 1;
    check("flush_enable", flush_cnt, exp_flush);
    check("hunt_ph_gate", int'(cdr_ph_valid_o), 1);

    // Nominal frame: PHR 05, payload 01..05
    nom_fcs = (FCS_ON != 0 && crc_stream(40'h0504030201, 40) == 16'h0000) ? 1 : 0;
    expect_ev(K_SFD, 0, -1);
    for (int b = 1; b <= 5; b++) expect_ev(K_BYTE, b, -1);
    expect_ev(K_DONE, 256 | (nom_fcs << 7) | 5, -1);
    send_frame(8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    idle(3);
    exp_flush++;
    check("flush_nominal", flush_cnt, exp_flush);
    check("nominal_drained", exp_q.size(), 0);

    // Short preamble rejected, full preamble accepted, then illegal length
    send_zeros(10);
    send_byte(8'hA7);
    check("short_pre_busy", int'(busy_o), 0);
    expect_ev(K_SFD, 0, -1);
    send_zeros(24);
    send_byte(8'hA7);
    check("sfd_busy", int'(busy_o), 1);
    send_byte(8'h03);
    expect_ev(K_ERR, 1, cyc);
    idle(3);
    exp_flush++;
    check("flush_badlen", flush_cnt, exp_flush);
    check("badlen_busy", int'(busy_o), 0);

    // Stall after two payload bytes
    expect_ev(K_SFD, 0, -1);
    expect_ev(K_BYTE, 8'h11, -1);
    expect_ev(K_BYTE, 8'h22, -1);
    send_zeros(32);
    send_byte(8'hA7);
    send_byte(8'h06);
    send_byte(8'h11);
    send_byte(8'h22);
    expect_ev(K_ERR, 1, cyc + TIMEOUT_CYC);
    idle(TIMEOUT_CYC + 8);
    exp_flush++;
    check("flush_stall", flush_cnt, exp_flush);

    // Disable during the third payload byte
    expect_ev(K_SFD, 0, -1);
    expect_ev(K_BYTE, 8'hAA, -1);
    expect_ev(K_BYTE, 8'h55, -1);
    send_zeros(32);
    send_byte(8'hA7);
    send_byte(8'h05);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rx_en_i   = 1'b0;
    data_en_i = 1'b1;
    data_i    = 1'b1;
    @(posedge clk);
    #1;
    data_en_i = 1'b0;
    check("disable_busy", int'(busy_o), 0);
    for (int i = 0; i < 4; i++) begin
      ph_valid_i = ~ph_valid_i;
      #1;
      check("disable_ph_gate", int'(cdr_ph_valid_o), 0);
      @(posedge clk);
      #1;
    end
    exp_flush++;
    check("flush_disable", flush_cnt, exp_flush);
    rx_en_i = 1'b1;
    idle(2);
    exp_flush++;
    check("flush_reenable", flush_cnt, exp_flush);

    // FCS frames back to back: good FCS, then one FCS bit flipped
    fcs = crc_stream({16'h0000, 24'h560002}, 24);
    for (int f = 0; f < 2; f++) begin
      expect_ev(K_SFD, 0, -1);
      expect_ev(K_BYTE, 8'h02, -1);
      expect_ev(K_BYTE, 8'h00, -1);
      expect_ev(K_BYTE, 8'h56, -1);
      expect_ev(K_BYTE, (f == 0) ? int'(fcs[7:0]) : int'(fcs[7:0] ^ 8'h10), -1);
      expect_ev(K_BYTE, int'(fcs[15:8]), -1);
      expect_ev(K_DONE, 256 | (((f == 0) ? FCS_ON : 0) << 7) | 5, -1);
    end
    send_frame(8'h05, 8'h02, 8'h00, 8'h56, fcs[7:0], fcs[15:8]);
    send_frame(8'h05, 8'h02, 8'h00, 8'h56, fcs[7:0] ^ 8'h10, fcs[15:8]);
    idle(4);
    exp_flush += 2;
    check("flush_fcs", flush_cnt, exp_flush);
    check("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation ran past 1 ms, expected completion");
    $fatal(1, "timeout");
  end

endmodule
